// File: rtl/bus_pkg.sv
// Shared bus types: demux FSM states and the request record used by bus blocks.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } bus_demux_state_t;

  typedef struct packed {
    logic [BUS_ADDR_WIDTH-1:0]   addr;
    logic                        write;
    logic [BUS_DATA_WIDTH-1:0]   wdata;
    logic [BUS_DATA_WIDTH/8-1:0] wstrb;
  } bus_req_t;

endpackage

// File: rtl/bus_demux_if.sv
// Core-side request/response and target-side fan-out signals of bus_demux.
interface bus_demux_if #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic                      req_write;
  logic [WIDTH-1:0]          req_wdata;
  logic [WIDTH/8-1:0]        req_wstrb;
  logic                      rsp_valid;
  logic [WIDTH-1:0]          rsp_rdata;
  logic                      rsp_error;
  logic [CHANNELS-1:0]       tgt_valid;
  logic [CHANNELS-1:0]       tgt_ready;
  logic [ADDR_WIDTH-1:0]     tgt_addr;
  logic                      tgt_write;
  logic [WIDTH-1:0]          tgt_wdata;
  logic [WIDTH/8-1:0]        tgt_wstrb;
  logic [CHANNELS-1:0]       tgt_rsp_valid;
  logic [CHANNELS*WIDTH-1:0] tgt_rsp_rdata;

  // The demux itself sees the bus through the slave view.
  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output tgt_valid, tgt_addr, tgt_write, tgt_wdata, tgt_wstrb,
    input  tgt_ready, tgt_rsp_valid, tgt_rsp_rdata
  );

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  tgt_valid, tgt_addr, tgt_write, tgt_wdata, tgt_wstrb,
    output tgt_ready, tgt_rsp_valid, tgt_rsp_rdata
  );

endinterface

// File: rtl/bus_demux_decode.sv
// Address decoder: extracts the channel field and flags indices beyond CHANNELS.
module bus_demux_decode
  import bus_pkg::*;
#(
  parameter  int CHANNELS   = 2,
  parameter  int ADDR_WIDTH = 32,
  parameter  int SEL_LSB    = 28,
  localparam int CH_W       = $clog2(CHANNELS)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [CH_W-1:0]       ch_o,
  output logic                  in_range_o
);

  assign ch_o       = addr_i[SEL_LSB +: CH_W];
  assign in_range_o = (int'(ch_o) < CHANNELS);

endmodule

// File: rtl/bus_demux.sv
// Single-outstanding bus demultiplexer: routes one core request to an address-selected
// target and returns that target's response as a registered one-cycle pulse.
module bus_demux
  import bus_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = BUS_DATA_WIDTH,
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int SEL_LSB    = 28
) (
  input  logic        clock,
  input  logic        reset,
  bus_demux_if.slave  bus
);

  localparam int CH_W = $clog2(CHANNELS);

  bus_demux_state_t  state_q, state_d;
  bus_req_t          req_q, req_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              error_q, error_d;
  logic [CH_W-1:0]   dec_ch;
  logic              dec_ok;
  logic [WIDTH-1:0]  sel_rdata;

  bus_demux_decode #(
    .CHANNELS   (CHANNELS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_LSB    (SEL_LSB)
  ) u_decode (
    .addr_i     (bus.req_addr),
    .ch_o       (dec_ch),
    .in_range_o (dec_ok)
  );

  assign sel_rdata = bus.tgt_rsp_rdata[int'(ch_q)*WIDTH +: WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      ch_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ch_q    <= ch_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Outputs depend on state and registers only, so no input reaches an output combinationally.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    ch_d          = ch_q;
    rdata_d       = rdata_q;
    error_d       = error_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.tgt_valid = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          req_d.addr  = BUS_ADDR_WIDTH'(bus.req_addr);
          req_d.write = bus.req_write;
          req_d.wdata = BUS_DATA_WIDTH'(bus.req_wdata);
          req_d.wstrb = (BUS_DATA_WIDTH/8)'(bus.req_wstrb);
          ch_d        = dec_ch;
          if (dec_ok) begin
            state_d = ISSUE;
          end else begin
            error_d = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      ISSUE: begin
        bus.tgt_valid = CHANNELS'(1) << ch_q;
        if (bus.tgt_ready[ch_q]) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Only the addressed target may complete the transaction; writes return zero data.
        if (bus.tgt_rsp_valid[ch_q]) begin
          rdata_d = req_q.write ? '0 : sel_rdata;
          error_d = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tgt_addr  = ADDR_WIDTH'(req_q.addr);
  assign bus.tgt_write = req_q.write;
  assign bus.tgt_wdata = WIDTH'(req_q.wdata);
  assign bus.tgt_wstrb = (WIDTH/8)'(req_q.wstrb);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;

endmodule

// File: tb/tb_bus_demux.sv
// Directed bench for bus_demux: a 2-channel and a 3-channel instance, with a response scoreboard.
module tb_bus_demux;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t q2[$];
  exp_t q3[$];

  bus_demux_if #(.CHANNELS(2), .WIDTH(32), .ADDR_WIDTH(32)) m2 ();
  bus_demux_if #(.CHANNELS(3), .WIDTH(32), .ADDR_WIDTH(32)) m3 ();

  bus_demux #(.CHANNELS(2), .WIDTH(32), .ADDR_WIDTH(32), .SEL_LSB(28)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (m2.slave)
  );

  bus_demux #(.CHANNELS(3), .WIDTH(32), .ADDR_WIDTH(32), .SEL_LSB(28)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (m3.slave)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic w,
                               input logic [31:0] d, input logic [3:0] s);
    m2.req_valid = v;
    m2.req_addr  = a;
    m2.req_write = w;
    m2.req_wdata = d;
    m2.req_wstrb = s;
  endtask

  // Every response pulse is matched against the oldest expected response of that instance.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (m2.rsp_valid) begin
      if (q2.size() == 0) begin
        checkOutput("dut2_unexpected_rsp", 1, 0);
      end else begin
        e = q2.pop_front();
        checkOutput("dut2_rsp_rdata", m2.rsp_rdata, e.rdata);
        checkOutput("dut2_rsp_error", m2.rsp_error, e.err);
      end
    end
    if (m3.rsp_valid) begin
      if (q3.size() == 0) begin
        checkOutput("dut3_unexpected_rsp", 1, 0);
      end else begin
        e = q3.pop_front();
        checkOutput("dut3_rsp_rdata", m3.rsp_rdata, e.rdata);
        checkOutput("dut3_rsp_error", m3.rsp_error, e.err);
      end
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0);
    m2.tgt_ready = '0; m2.tgt_rsp_valid = '0; m2.tgt_rsp_rdata = '0;
    m3.req_valid = 0; m3.req_addr = 0; m3.req_write = 0; m3.req_wdata = 0; m3.req_wstrb = 0;
    m3.tgt_ready = '0; m3.tgt_rsp_valid = '0; m3.tgt_rsp_rdata = '0;
    reset = 1'b1;
    repeat (2) tick();

    $display("[TB] reset values");
    checkOutput("rst_req_ready", m2.req_ready, 1);
    checkOutput("rst_rsp_valid", m2.rsp_valid, 0);
    checkOutput("rst_rsp_rdata", m2.rsp_rdata, 0);
    checkOutput("rst_rsp_error", m2.rsp_error, 0);
    checkOutput("rst_tgt_valid", m2.tgt_valid, 0);
    checkOutput("rst_tgt_addr", m2.tgt_addr, 0);
    checkOutput("rst_tgt_write", m2.tgt_write, 0);
    checkOutput("rst_tgt_wdata", m2.tgt_wdata, 0);
    checkOutput("rst_tgt_wstrb", m2.tgt_wstrb, 0);
    checkOutput("rst3_tgt_valid", m3.tgt_valid, 0);
    checkOutput("rst3_req_ready", m3.req_ready, 1);
    reset = 1'b0;
    tick();

    $display("[TB] read channel 1, best-case latency");
    applyStimulus(1, 32'h1000_0004, 0, 0, 0);
    m2.tgt_ready = 2'b10;
    q2.push_back('{32'hDEADBEEF, 1'b0});
    tick();
    checkOutput("t1_tgt_valid", m2.tgt_valid, 2'b10);
    checkOutput("t1_req_ready", m2.req_ready, 0);
    checkOutput("t1_tgt_addr", m2.tgt_addr, 32'h1000_0004);
    checkOutput("t1_tgt_write", m2.tgt_write, 0);
    m2.req_valid = 0;
    tick();
    checkOutput("t1_wait_tgt_valid", m2.tgt_valid, 0);
    m2.tgt_ready = 2'b00;
    m2.tgt_rsp_valid = 2'b10;
    m2.tgt_rsp_rdata = {32'hDEADBEEF, 32'h0BADF00D};
    tick();
    checkOutput("t1_rsp_valid_c3", m2.rsp_valid, 1);
    m2.tgt_rsp_valid = 2'b00;
    tick();
    checkOutput("t1_rsp_pulse", m2.rsp_valid, 0);
    checkOutput("t1_idle_ready", m2.req_ready, 1);

    $display("[TB] write channel 0, target stalls");
    applyStimulus(1, 32'h0000_0010, 1, 32'h1234_5678, 4'b0011);
    m2.tgt_ready = 2'b00;
    q2.push_back('{32'h0, 1'b0});
    tick();
    applyStimulus(0, 32'hFFFF_FFFF, 0, 32'h0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_tgt_valid", m2.tgt_valid, 2'b01);
      checkOutput("t2_tgt_addr", m2.tgt_addr, 32'h0000_0010);
      checkOutput("t2_tgt_wdata", m2.tgt_wdata, 32'h1234_5678);
      checkOutput("t2_tgt_wstrb", m2.tgt_wstrb, 4'b0011);
      checkOutput("t2_tgt_write", m2.tgt_write, 1);
      checkOutput("t2_req_ready", m2.req_ready, 0);
      if (i == 3) m2.tgt_ready = 2'b01;
      tick();
    end
    checkOutput("t2_wait_tgt_valid", m2.tgt_valid, 0);
    checkOutput("t2_wait_req_ready", m2.req_ready, 0);
    m2.tgt_ready = 2'b00;
    m2.tgt_rsp_valid = 2'b01;
    m2.tgt_rsp_rdata = {32'h0, 32'hAAAA_5555};
    tick();
    checkOutput("t2_rsp_valid", m2.rsp_valid, 1);
    m2.tgt_rsp_valid = 2'b00;
    tick();
    checkOutput("t2_rsp_pulse", m2.rsp_valid, 0);

    $display("[TB] cross-channel noise");
    applyStimulus(1, 32'h0000_0020, 0, 0, 0);
    m2.tgt_ready = 2'b01;
    q2.push_back('{32'h0000_0055, 1'b0});
    tick();
    m2.req_valid = 0;
    tick();
    m2.tgt_ready = 2'b00;
    m2.tgt_rsp_valid = 2'b10;
    m2.tgt_rsp_rdata = {32'hFFFF_FFFF, 32'h1111_1111};
    tick();
    checkOutput("t3_noise_ignored", m2.rsp_valid, 0);
    m2.tgt_rsp_valid = 2'b01;
    m2.tgt_rsp_rdata = {32'hFFFF_FFFF, 32'h0000_0055};
    tick();
    checkOutput("t3_rsp_valid", m2.rsp_valid, 1);
    m2.tgt_rsp_valid = 2'b00;
    tick();

    $display("[TB] three channels: read channel 2, then decode error");
    m3.req_valid = 1;
    m3.req_addr = 32'h2000_0000;
    m3.tgt_ready = 3'b100;
    q3.push_back('{32'hCAFE_F00D, 1'b0});
    tick();
    checkOutput("t4_ch2_tgt_valid", m3.tgt_valid, 3'b100);
    m3.req_valid = 0;
    tick();
    m3.tgt_ready = 3'b000;
    m3.tgt_rsp_valid = 3'b100;
    m3.tgt_rsp_rdata = {32'hCAFE_F00D, 32'h0000_0001, 32'h0000_0002};
    tick();
    checkOutput("t4_ch2_rsp_valid", m3.rsp_valid, 1);
    m3.tgt_rsp_valid = 3'b000;
    tick();
    m3.req_valid = 1;
    m3.req_addr = 32'h3000_0000;
    q3.push_back('{32'h0, 1'b1});
    tick();
    checkOutput("t4_err_tgt_valid", m3.tgt_valid, 0);
    checkOutput("t4_err_rsp_valid", m3.rsp_valid, 1);
    m3.req_valid = 0;
    tick();
    checkOutput("t4_err_after_tgt_valid", m3.tgt_valid, 0);
    checkOutput("t4_err_after_rsp_valid", m3.rsp_valid, 0);
    checkOutput("t4_err_hold", m3.rsp_error, 1);
    checkOutput("t4_err_ready", m3.req_ready, 1);

    $display("[TB] reset mid-WAIT");
    applyStimulus(1, 32'h0000_0030, 0, 0, 0);
    m2.tgt_ready = 2'b01;
    tick();
    m2.req_valid = 0;
    tick();
    m2.tgt_ready = 2'b00;
    checkOutput("t5_wait_req_ready", m2.req_ready, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_rst_req_ready", m2.req_ready, 1);
    checkOutput("t5_rst_tgt_valid", m2.tgt_valid, 0);
    checkOutput("t5_rst_rsp_rdata", m2.rsp_rdata, 0);
    tick();
    tick();
    reset = 1'b0;
    m2.tgt_rsp_valid = 2'b01;
    m2.tgt_rsp_rdata = {32'h0, 32'h7777_7777};
    for (int i = 0; i < 3; i++) begin
      tick();
      m2.tgt_rsp_valid = 2'b00;
      checkOutput("t5_no_rsp", m2.rsp_valid, 0);
    end

    $display("[TB] reset during ISSUE");
    applyStimulus(1, 32'h1000_0000, 0, 0, 0);
    m2.tgt_ready = 2'b00;
    tick();
    checkOutput("t5b_issue_tgt_valid", m2.tgt_valid, 2'b10);
    m2.req_valid = 0;
    #2 reset = 1'b1;
    #1;
    checkOutput("t5b_async_tgt_valid", m2.tgt_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("t5b_rsp_valid", m2.rsp_valid, 0);
    checkOutput("t5b_req_ready", m2.req_ready, 1);

    $display("[TB] back-to-back reads");
    applyStimulus(1, 32'h0000_0040, 0, 0, 0);
    m2.tgt_ready = 2'b11;
    q2.push_back('{32'hA0A0_A0A0, 1'b0});
    q2.push_back('{32'hB1B1_B1B1, 1'b0});
    tick();
    checkOutput("t6_first_tgt_valid", m2.tgt_valid, 2'b01);
    m2.req_addr = 32'h1000_0044;
    tick();
    m2.tgt_rsp_valid = 2'b01;
    m2.tgt_rsp_rdata = {32'h5A5A_5A5A, 32'hA0A0_A0A0};
    tick();
    checkOutput("t6_first_rsp_valid", m2.rsp_valid, 1);
    checkOutput("t6_resp_not_ready", m2.req_ready, 0);
    m2.tgt_rsp_valid = 2'b00;
    tick();
    checkOutput("t6_idle_ready", m2.req_ready, 1);
    checkOutput("t6_idle_tgt_valid", m2.tgt_valid, 0);
    tick();
    checkOutput("t6_second_tgt_valid", m2.tgt_valid, 2'b10);
    checkOutput("t6_second_tgt_addr", m2.tgt_addr, 32'h1000_0044);
    m2.req_valid = 0;
    tick();
    m2.tgt_rsp_valid = 2'b10;
    m2.tgt_rsp_rdata = {32'hB1B1_B1B1, 32'h5A5A_5A5A};
    tick();
    checkOutput("t6_second_rsp_valid", m2.rsp_valid, 1);
    m2.tgt_rsp_valid = 2'b00;
    m2.tgt_ready = 2'b00;
    tick();
    tick();

    checkOutput("q2_drained", q2.size(), 0);
    checkOutput("q3_drained", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
